// File: rtl/dmem_mmio_responder_pkg.sv
// Shared constants for the data-memory responder: MMIO register offsets,
// TX_STAT bit positions and the default MMIO window base.
package riscv_mem_pkg;

  localparam logic [15:0] TX_DATA_OFF = 16'h0000;
  localparam logic [15:0] TX_STAT_OFF = 16'h0004;
  localparam logic [15:0] CYC_LO_OFF  = 16'h0008;
  localparam logic [15:0] CYC_HI_OFF  = 16'h000C;

  localparam int STAT_FULL_BIT  = 0;
  localparam int STAT_EMPTY_BIT = 1;
  localparam int STAT_OVF_BIT   = 2;
  localparam int STAT_COUNT_LSB = 8;

  localparam logic [31:0] MMIO_BASE_DEFAULT = 32'hFFFF_0000;

endpackage

// File: rtl/dmem_mmio_responder_if.sv
// Core data port plus the TX byte stream; master = core/system side, slave = responder.
// Loads are combinational, stores and TX pops take effect at the clock edge.
interface dmem_mmio_responder_if;

  logic        dmem_wren;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_data_in;
  logic [31:0] dmem_data_out;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;

  modport master (
    output dmem_wren, dmem_addr, dmem_data_in, tx_ready,
    input  dmem_data_out, tx_valid, tx_data
  );

  modport slave (
    input  dmem_wren, dmem_addr, dmem_data_in, tx_ready,
    output dmem_data_out, tx_valid, tx_data
  );

endinterface

// File: rtl/dmem_mmio_responder_byte_fifo.sv
// Small register FIFO; head is readable combinationally from storage, push/pop commit at posedge.
// A push into a full FIFO is accepted only when a pop happens in the same cycle, otherwise drop_o flags it.
module byte_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_dat_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_dat_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic                     drop_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             pop_go, push_go;

  assign full_o     = (count_q == CW'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign head_dat_o = mem_q[rd_ptr_q];

  // A pop frees a slot this edge, so a same-cycle push into a full FIFO still fits.
  assign pop_go  = pop_i && !empty_o;
  assign push_go = push_i && (!full_o || pop_go);
  assign drop_o  = push_i && !push_go;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_go) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_go)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push_go && !pop_go)      count_d = count_q + CW'(1);
    else if (!push_go && pop_go) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_go && !reset) mem_q[wr_ptr_q] <= push_dat_i;
  end

endmodule

// File: rtl/dmem_mmio_responder.sv
// Data-memory responder: word RAM plus MMIO window (TX byte FIFO, status, optional cycle counter).
// Loads combinational, stores at posedge; define DMEM_CYCLE_COUNTER_EN to build the 64-bit cycle counter.
module dmem_mmio_responder
  import riscv_mem_pkg::*;
#(
  parameter int          RAM_WORDS = 1024,
  parameter int          TX_DEPTH  = 8,
  parameter logic [31:0] MMIO_BASE = MMIO_BASE_DEFAULT
) (
  input logic                  clk,
  input logic                  reset,
  dmem_mmio_responder_if.slave bus
);

  localparam int IW = $clog2(RAM_WORDS);
  localparam int CW = $clog2(TX_DEPTH) + 1;

  logic          ram_hit, mmio_hit;
  logic [15:0]   off;
  logic [IW-1:0] ram_idx;
  logic          txd_wr, txs_wr;
  logic          tx_full, tx_empty, tx_drop;
  logic [CW-1:0] tx_count;
  logic          ovf_q, ovf_d;
  logic [31:0]   stat;
  logic [31:0]   cyc_lo_val, cyc_hi_val;
  logic [31:0]   rd_dat;
  logic [31:0]   ram_q [RAM_WORDS];

  assign ram_hit  = (bus.dmem_addr < 32'(4 * RAM_WORDS));
  assign mmio_hit = (bus.dmem_addr[31:16] == MMIO_BASE[31:16]);
  assign off      = {bus.dmem_addr[15:2], 2'b00};
  assign ram_idx  = bus.dmem_addr[IW+1:2];
  assign txd_wr   = bus.dmem_wren && mmio_hit && (off == TX_DATA_OFF);
  assign txs_wr   = bus.dmem_wren && mmio_hit && (off == TX_STAT_OFF);

  // RAM keeps its contents through reset, so stores are not gated by it.
  always_ff @(posedge clk) begin
    if (bus.dmem_wren && ram_hit) ram_q[ram_idx] <= bus.dmem_data_in;
  end

  byte_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk        (clk),
    .reset      (reset),
    .push_i     (txd_wr),
    .push_dat_i (bus.dmem_data_in[7:0]),
    .pop_i      (bus.tx_valid && bus.tx_ready),
    .head_dat_o (bus.tx_data),
    .full_o     (tx_full),
    .empty_o    (tx_empty),
    .drop_o     (tx_drop),
    .count_o    (tx_count)
  );

  assign bus.tx_valid = !tx_empty;

  always_comb begin
    ovf_d = ovf_q;
    if (tx_drop)     ovf_d = 1'b1;
    else if (txs_wr) ovf_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) ovf_q <= 1'b0;
    else       ovf_q <= ovf_d;
  end

  always_comb begin
    stat                           = '0;
    stat[STAT_COUNT_LSB +: 8]      = 8'(tx_count);
    stat[STAT_OVF_BIT]             = ovf_q;
    stat[STAT_EMPTY_BIT]           = tx_empty;
    stat[STAT_FULL_BIT]            = tx_full;
  end

`ifdef DMEM_CYCLE_COUNTER_EN
  logic [63:0] cyc_q, cyc_d;
  logic [31:0] cyc_hi_q, cyc_hi_d;
  logic        cyc_lo_rd;

  // Reading the low word snapshots the high word so a LO-then-HI pair is coherent.
  assign cyc_lo_rd = mmio_hit && (off == CYC_LO_OFF) && !bus.dmem_wren;

  always_comb begin
    cyc_d    = cyc_q + 64'd1;
    cyc_hi_d = cyc_hi_q;
    if (cyc_lo_rd) cyc_hi_d = cyc_q[63:32];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cyc_q    <= '0;
      cyc_hi_q <= '0;
    end else begin
      cyc_q    <= cyc_d;
      cyc_hi_q <= cyc_hi_d;
    end
  end

  assign cyc_lo_val = cyc_q[31:0];
  assign cyc_hi_val = cyc_hi_q;
`else
  assign cyc_lo_val = '0;
  assign cyc_hi_val = '0;
`endif

  always_comb begin
    rd_dat = '0;
    if (ram_hit) begin
      rd_dat = ram_q[ram_idx];
    end else if (mmio_hit) begin
      case (off)
        TX_STAT_OFF: rd_dat = stat;
        CYC_LO_OFF:  rd_dat = cyc_lo_val;
        CYC_HI_OFF:  rd_dat = cyc_hi_val;
        default:     rd_dat = '0;
      endcase
    end
  end

  assign bus.dmem_data_out = rd_dat;

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Directed bench for dmem_mmio_responder with a queue model of the TX stream.
module tb_dmem_mmio_responder;

  localparam logic [31:0] MB  = 32'hFFFF_0000;
  localparam logic [31:0] TXD = MB + 32'h0;
  localparam logic [31:0] TXS = MB + 32'h4;
  localparam logic [31:0] CLO = MB + 32'h8;
  localparam logic [31:0] CHI = MB + 32'hC;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dmem_mmio_responder_if bus();

  dmem_mmio_responder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic       m_ovf = 1'b0;
  logic [31:0] lo1, lo2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] stat_exp();
    int n;
    n = exp_q.size();
    return {16'b0, 8'(n), 5'b0, m_ovf, (n == 0), (n == 8)};
  endfunction

  // Checks the stream head, updates the model for this edge, then advances one clock.
  task automatic tick();
    bit pop, push, full;
    #2;
    if (!reset) begin
      chk("tx_valid", {31'b0, bus.tx_valid}, {31'b0, exp_q.size() != 0});
      if (exp_q.size() != 0) chk("tx_data", {24'b0, bus.tx_data}, {24'b0, exp_q[0]});
    end
    pop  = (exp_q.size() != 0) && bus.tx_ready && !reset;
    push = bus.dmem_wren && (bus.dmem_addr == TXD) && !reset;
    full = (exp_q.size() == 8);
    if (pop) void'(exp_q.pop_front());
    if (push) begin
      if (!full || pop) exp_q.push_back(bus.dmem_data_in[7:0]);
      else              m_ovf = 1'b1;
    end
    if (bus.dmem_wren && (bus.dmem_addr == TXS) && !reset) m_ovf = 1'b0;
    if (reset) begin
      exp_q.delete();
      m_ovf = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.dmem_wren    = 1'b1;
    bus.dmem_addr    = a;
    bus.dmem_data_in = d;
    tick();
    bus.dmem_wren    = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] e, input string tag);
    bus.dmem_wren = 1'b0;
    bus.dmem_addr = a;
    #2;
    chk(tag, bus.dmem_data_out, e);
    tick();
  endtask

  initial begin
    reset            = 1'b1;
    bus.dmem_wren    = 1'b0;
    bus.dmem_addr    = 32'h0;
    bus.dmem_data_in = 32'h0;
    bus.tx_ready     = 1'b0;
    @(posedge clk);
    #1;
    tick();
    reset = 1'b0;

    // Reset state
    chk("rst_tx_valid", {31'b0, bus.tx_valid}, 32'h0);
    rd(TXS, 32'h0000_0002, "rst_stat");

    // RAM access, alignment and out-of-range decode
    wr(32'h10, 32'hDEADBEEF);
    rd(32'h10, 32'hDEADBEEF, "ram_rd_10");
    rd(32'h13, 32'hDEADBEEF, "ram_rd_13");
    rd(32'h4000, 32'h0, "ram_oob");
    bus.dmem_wren = 1'b1; bus.dmem_addr = 32'h10; bus.dmem_data_in = 32'h1234_5678;
    #2;
    chk("ram_rdw_old", bus.dmem_data_out, 32'hDEADBEEF);
    tick();
    bus.dmem_wren = 1'b0;
    rd(32'h10, 32'h1234_5678, "ram_new");
    wr(32'h10, 32'hDEADBEEF);
    rd(TXD, 32'h0, "txdata_rd0");
    rd(MB + 32'h10, 32'h0, "mmio_unmapped");
    rd(32'h8000_0000, 32'h0, "unmapped");

    // TX ordering
    wr(TXD, 32'h41); wr(TXD, 32'h42); wr(TXD, 32'h43);
    rd(TXS, stat_exp(), "stat_cnt3");
    chk("stat_cnt3_val", stat_exp(), 32'h0000_0300);
    bus.tx_ready = 1'b1;
    repeat (3) tick();
    rd(TXS, 32'h0000_0002, "stat_drained");
    bus.tx_ready = 1'b0;

    // Overflow and clear
    for (int i = 0; i < 8; i++) wr(TXD, 32'h50 + i);
    wr(TXD, 32'h77);
    rd(TXS, 32'h0000_0805, "stat_ovf");
    wr(TXS, 32'hFFFF_FFFF);
    rd(TXS, 32'h0000_0801, "stat_ovf_clr");
    bus.tx_ready = 1'b1;
    repeat (8) tick();
    bus.tx_ready = 1'b0;

    // Push and pop in the same cycle on a full FIFO
    for (int i = 0; i < 8; i++) wr(TXD, 32'h60 + i);
    bus.tx_ready = 1'b1;
    wr(TXD, 32'h99);
    bus.tx_ready = 1'b0;
    rd(TXS, 32'h0000_0801, "stat_full_pp");
    chk("last_byte", {24'b0, exp_q[7]}, 32'h99);
    bus.tx_ready = 1'b1;
    repeat (8) tick();
    bus.tx_ready = 1'b0;
    rd(TXS, 32'h0000_0002, "stat_pp_drained");

    // Reset mid-stream
    for (int i = 0; i < 5; i++) wr(TXD, 32'h70 + i);
    rd(TXS, 32'h0000_0500, "stat_pre_rst");
    bus.tx_ready = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.tx_ready = 1'b0;
    chk("rst2_tx_valid", {31'b0, bus.tx_valid}, 32'h0);
    rd(TXS, 32'h0000_0002, "rst2_stat");
    rd(32'h10, 32'hDEADBEEF, "rst2_ram");

`ifdef DMEM_CYCLE_COUNTER_EN
    bus.dmem_addr = CLO;
    #2;
    lo1 = bus.dmem_data_out;
    tick();
    repeat (9) tick();
    bus.dmem_addr = CLO;
    #2;
    lo2 = bus.dmem_data_out;
    tick();
    chk("cyc_diff", lo2 - lo1, 32'd10);
    rd(CHI, 32'h0, "cyc_hi");
`else
    rd(CLO, 32'h0, "cyc_lo_off");
    rd(CHI, 32'h0, "cyc_hi_off");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
